// File: rtl/rx_control_se.sv
// rx_control_se: assembles two received UART bytes (low byte first) into a
// 16-bit word. A three-state FSM holds the low byte, waits for the high byte,
// then presents the word with a one-cycle data_valid pulse.
// Optional feature macro: RX_CONTROL_TIMEOUT_EN -- when defined, a partial word
// is discarded if the high byte does not arrive within INTER_BYTE_TIMEOUT
// cycles, and rx_timeout pulses for one cycle. Without it the FSM waits
// indefinitely and rx_timeout is tied low.
module rx_control_se #(
  parameter int unsigned INTER_BYTE_TIMEOUT = 2000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic [15:0] dataOut16,
  output logic        data_valid,
  output logic        rx_busy,
  output logic        rx_timeout
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_BYTE_1 = 2'd1,
    WORD_READY  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  low_byte;
  logic        load_low;
  logic        load_word;
  logic        timeout_hit;

`ifdef RX_CONTROL_TIMEOUT_EN
  logic [31:0] hold_state_timer;

  // The arriving byte wins over the timeout, so rx_ready must be low to expire.
  assign timeout_hit = (state == WAIT_BYTE_1) &&
                       (hold_state_timer >= INTER_BYTE_TIMEOUT) &&
                       !rx_ready;

  // Inter-byte timer: counts cycles spent in WAIT_BYTE_1, zero elsewhere.
  // NOTE: sequential state is always written with non-blocking (<=) so every
  // register samples the pre-edge values of its inputs, regardless of order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_state_timer <= 32'd0;
    end else if (state == WAIT_BYTE_1) begin
      hold_state_timer <= hold_state_timer + 32'd1;
    end else begin
      hold_state_timer <= 32'd0;
    end
  end

  // Registered one-cycle pulse following the timeout transition.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_timeout <= 1'b0;
    end else begin
      rx_timeout <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rx_timeout  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and load-enable decode.
  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load_low   = 1'b0;
    load_word  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_ready) begin
          load_low   = 1'b1;
          state_next = WAIT_BYTE_1;
        end
      end
      WAIT_BYTE_1: begin
        if (rx_ready) begin
          load_word  = 1'b1;
          state_next = WORD_READY;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      WORD_READY: begin
        // A byte arriving here starts the next word immediately.
        if (rx_ready) begin
          load_low   = 1'b1;
          state_next = WAIT_BYTE_1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Low-byte holding register; cleared when a partial word is discarded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      low_byte <= 8'h00;
    end else if (load_low) begin
      low_byte <= rx_data;
    end else if (timeout_hit) begin
      low_byte <= 8'h00;
    end
  end

  // Output word: updated only on the WAIT_BYTE_1 -> WORD_READY transition.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dataOut16 <= 16'h0000;
    end else if (load_word) begin
      dataOut16 <= {rx_data, low_byte};
    end
  end

  // Status outputs decode directly from the registered state, so they clear
  // with the asynchronous reset.
  assign data_valid = (state == WORD_READY);
  assign rx_busy    = (state == WAIT_BYTE_1);

endmodule

// File: doc/rx_control_se.md
RX_CONTROL_SE -- requirements
Module: rx_control_se

Interface
REQ-001 The block SHALL have parameter INTER_BYTE_TIMEOUT, default 2000000, meaning the maximum number of clock cycles to wait for the high byte after the low byte is received.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_ready, input, 1 bit: one-cycle pulse from the UART receive driver indicating rx_data holds a new byte.
REQ-005 The block SHALL have port rx_data, input, 8 bits: received byte, valid only when rx_ready=1.
REQ-006 The block SHALL have port dataOut16, output, 16 bits: last fully assembled word, {byte1, byte0}.
REQ-007 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse, high in the cycle after dataOut16 is updated.
REQ-008 The block SHALL have port rx_busy, output, 1 bit: high while a low byte is held and the high byte is awaited.
REQ-009 The block SHALL have port rx_timeout, output, 1 bit: one-cycle pulse when a partial word is discarded.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, WAIT_BYTE_1 and WORD_READY.
REQ-011 In IDLE with rx_ready=1, the block SHALL latch rx_data into the internal low-byte register and go to WAIT_BYTE_1; otherwise it SHALL stay in IDLE.
REQ-012 In WAIT_BYTE_1 with rx_ready=1, the block SHALL load dataOut16 <= {rx_data, low byte} and go to WORD_READY.
REQ-013 In WORD_READY, data_valid SHALL be 1, so the latency is one cycle from the rx_ready of byte 1 to data_valid.
REQ-014 In WORD_READY with rx_ready=1, the block SHALL latch the byte as the next low byte and go to WAIT_BYTE_1 (back-to-back words lose no byte); otherwise it SHALL go to IDLE.
REQ-015 A 32-bit hold_state_timer SHALL increment every cycle in WAIT_BYTE_1 and SHALL clear to 0 in all other states.
REQ-016 Timeout condition: state WAIT_BYTE_1, hold_state_timer >= INTER_BYTE_TIMEOUT, and rx_ready=0.
REQ-017 On the timeout condition, the block SHALL go to IDLE, discard the low byte, and leave dataOut16 unchanged.
REQ-018 If rx_ready=1 in the same cycle the timeout threshold is reached, the byte SHALL be accepted as byte 1; the receive event wins.
REQ-019 dataOut16 SHALL change only on the transition WAIT_BYTE_1 -> WORD_READY and SHALL hold its value otherwise.
REQ-020 rx_busy SHALL be 1 exactly when state == WAIT_BYTE_1.
REQ-021 rx_timeout SHALL be registered and high for exactly one cycle after the timeout transition.
REQ-022 Bytes SHALL be interpreted low byte first, then high byte, with no framing or header byte.

Reset
REQ-023 When reset_n=0, the block SHALL immediately, without waiting for a clock edge, set the FSM to IDLE, dataOut16=16'h0000, the low-byte register=8'h00, hold_state_timer=0, data_valid=0 and rx_timeout=0.
REQ-024 A reset asserted during WAIT_BYTE_1 or WORD_READY SHALL abort the word, and no data_valid pulse SHALL occur afterward for that word.
REQ-025 After reset_n deasserts, the first accepted rx_ready SHALL be treated as byte 0.

Configuration
REQ-026 With macro RX_CONTROL_TIMEOUT_EN defined, REQ-015 to REQ-018 and REQ-021 SHALL be implemented.
REQ-027 Without RX_CONTROL_TIMEOUT_EN: no timer is instantiated, WAIT_BYTE_1 waits indefinitely for rx_ready, and rx_timeout is tied to 0.

Verification (bench uses INTER_BYTE_TIMEOUT=100, macro defined unless noted)
REQ-028 Scenario: rx_ready with 8'h34, then 10 cycles later rx_ready with 8'h12 -> dataOut16=16'h1234 and data_valid high for one cycle, one cycle after the second pulse.
REQ-029 Scenario: two words sent back-to-back, with the next rx_ready in the WORD_READY cycle (8'hCD, 8'hAB, 8'h01, 8'h00) -> data_valid pulses with 16'hABCD, then 16'h0001; no byte is lost.
REQ-030 Scenario: 8'h55 received, then no rx_ready for 150 cycles -> rx_timeout pulses once about 101 cycles after the byte, rx_busy falls, and dataOut16 keeps its prior value; the next two bytes 8'h78, 8'h56 give 16'h5678.
REQ-031 Scenario: byte 1 arrives in exactly the cycle where hold_state_timer=100 -> the word is accepted and there is no rx_timeout pulse.
REQ-032 Scenario: reset_n pulsed low mid-clock while in WAIT_BYTE_1 -> outputs clear asynchronously, no data_valid follows, and the next pair 8'hEF, 8'hBE gives 16'hBEEF.
REQ-033 Scenario: macro undefined, 8'h11 received, wait 10000 cycles, then 8'h22 received -> dataOut16=16'h2211 and rx_timeout never asserts.
